noc_packet_tx: RTL and testbench

//  Source-side packetizer: the injection end of the router lookup protocol. Takes a packet command
//  (unicast dest or multicast region) plus a payload stream. Emits one header flit, then payload

---
 rtl/noc_packet_tx.sv | 176 +++++++++++++++++
 tb/tb_noc_packet_tx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_packet_tx.sv
// noc_packet_tx: source-side packetizer feeding the local router input port.
// Accepts a unicast/multicast command, emits one header flit, then passes the
// payload stream through with out_last on the final flit.
// Optional build macro NOC_TX_OUTREG_EN: registers the output through a
// 2-entry skid buffer (+1 cycle latency, full throughput).
module noc_packet_tx #(
    parameter int FLIT_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_mcast,
    input  logic [3:0]            cmd_dest,
    input  logic [7:0]            cmd_bounds,
    input  logic [FLIT_WIDTH-14:0] cmd_tag,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  cmd_err,
    input  logic [FLIT_WIDTH-1:0] data_flit,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int TAG_WIDTH = FLIT_WIDTH - 13;

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        BODY
    } state_t;

    state_t                 state, state_next;
    logic [LEN_WIDTH-1:0]   rem, rem_next;
    logic [3:0]             dest_q;
    logic [7:0]             bounds_q;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic                   load;
    logic                   err_next;
    logic [FLIT_WIDTH-1:0]  header;
    logic [FLIT_WIDTH-1:0]  core_flit;
    logic                   core_last;
    logic                   core_valid;
    logic                   core_ready;
    logic [1:0]             c_y;
    logic [1:0]             c_x;
    logic                   mcast_ok;

    assign c_y = cmd_dest[3:2];
    assign c_x = cmd_dest[1:0];

    // Region must contain its central node: bounds = {west,south,east,north}
    assign mcast_ok = (cmd_bounds[1:0] >= c_y) && (cmd_bounds[5:4] <= c_y) &&
                      (cmd_bounds[3:2] >= c_x) && (cmd_bounds[7:6] <= c_x);

    // Forward flag (MSB) is always clear at injection
    assign header = {1'b0, tag_q, bounds_q, dest_q};

    // Next-state and core output decode
    always_comb begin
        state_next = state;
        rem_next   = rem;
        load       = 1'b0;
        err_next   = 1'b0;
        cmd_ready  = 1'b0;
        data_ready = 1'b0;
        core_valid = 1'b0;
        core_last  = 1'b0;
        core_flit  = '0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_mcast && !mcast_ok) begin
                        err_next = 1'b1;
                    end else begin
                        load       = 1'b1;
                        rem_next   = cmd_len;
                        state_next = HEAD;
                    end
                end
            end
            HEAD: begin
                core_valid = 1'b1;
                core_flit  = header;
                core_last  = (rem == '0);
                if (core_ready) begin
                    state_next = (rem == '0) ? IDLE : BODY;
                end
            end
            BODY: begin
                core_flit  = data_flit;
                core_valid = data_valid;
                data_ready = core_ready;
                core_last  = (rem == LEN_WIDTH'(1));
                if (data_valid && core_ready) begin
                    rem_next = rem - LEN_WIDTH'(1);
                    if (rem == LEN_WIDTH'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, remaining count, latched command fields and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rem      <= '0;
            dest_q   <= '0;
            bounds_q <= '0;
            tag_q    <= '0;
            cmd_err  <= 1'b0;
        end else begin
            state   <= state_next;
            rem     <= rem_next;
            cmd_err <= err_next;
            if (load) begin
                dest_q   <= cmd_dest;
                bounds_q <= cmd_mcast ? cmd_bounds : '0;
                tag_q    <= cmd_tag;
            end
        end
    end

`ifdef NOC_TX_OUTREG_EN
    logic [FLIT_WIDTH:0] skid [2];
    logic                rd_ptr;
    logic                wr_ptr;
    logic [1:0]          count;
    logic                push;
    logic                pop;

    // Upstream advances only while a skid slot is free
    assign core_ready = (count != 2'd2);
    assign push       = core_valid && core_ready;
    assign pop        = out_valid && out_ready;

    // Two-entry skid FIFO holding {last, flit}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                skid[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                skid[wr_ptr] <= {core_last, core_flit};
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign out_valid = (count != 2'd0);
    assign out_flit  = out_valid ? skid[rd_ptr][FLIT_WIDTH-1:0] : '0;
    assign out_last  = out_valid && skid[rd_ptr][FLIT_WIDTH];
`else
    assign core_ready = out_ready;
    assign out_flit   = core_flit;
    assign out_last   = core_last;
    assign out_valid  = core_valid;
`endif

endmodule

// File: tb/tb_noc_packet_tx.sv
// Randomized bench for noc_packet_tx against a flit-queue reference model.
module tb_noc_packet_tx;

    localparam int FW = 32;
    localparam int LW = 8;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_mcast;
    logic [3:0]    cmd_dest;
    logic [7:0]    cmd_bounds;
    logic [FW-14:0] cmd_tag;
    logic [LW-1:0] cmd_len;
    logic          cmd_err;
    logic [FW-1:0] data_flit;
    logic          data_valid;
    logic          data_ready;
    logic [FW-1:0] out_flit;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;

    noc_packet_tx #(
        .FLIT_WIDTH(FW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mcast (cmd_mcast),
        .cmd_dest  (cmd_dest),
        .cmd_bounds(cmd_bounds),
        .cmd_tag   (cmd_tag),
        .cmd_len   (cmd_len),
        .cmd_err   (cmd_err),
        .data_flit (data_flit),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .out_flit  (out_flit),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] flit;
        logic          last;
        logic          hdr;
    } exp_t;

    typedef struct {
        logic        mcast;
        logic [3:0]  dest;
        logic [7:0]  bounds;
        logic [18:0] tag;
        int unsigned len;
        int unsigned mode;   // 0: out_ready=1, 1: toggle, 2: random
    } cmd_t;

    exp_t          exp_q[$];
    logic [FW-1:0] dq[$];
    cmd_t          cmd_list[$];
    cmd_t          cur_cmd;
    int            n_checks = 0;
    int            n_fail   = 0;
    logic          err_exp  = 1'b0;
    bit            held_hdr = 0;
    logic [FW-1:0] held_flit;
    int unsigned   ready_mode = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Header value from the field layout: dest at bit 0, region at bit 4, tag at bit 12
    function automatic logic [FW-1:0] model_header(input cmd_t c);
        logic [63:0] v;
        v = 64'(c.dest) + (c.mcast ? 64'(c.bounds) : 64'd0) * 64'd16 + 64'(c.tag) * 64'd4096;
        return v[FW-1:0];
    endfunction

    function automatic bit model_legal(input cmd_t c);
        int cy, cx, n, e, s, w;
        cy = int'(c.dest) / 4;
        cx = int'(c.dest) % 4;
        n  = int'(c.bounds) % 4;
        e  = (int'(c.bounds) / 4) % 4;
        s  = (int'(c.bounds) / 16) % 4;
        w  = int'(c.bounds) / 64;
        return !c.mcast || (n >= cy && s <= cy && e >= cx && w <= cx);
    endfunction

    function automatic cmd_t mk_cmd(input logic mc, input logic [3:0] d, input logic [7:0] b,
                                    input logic [18:0] t, input int unsigned l, input int unsigned m);
        cmd_t c;
        c.mcast = mc; c.dest = d; c.bounds = b; c.tag = t; c.len = l; c.mode = m;
        return c;
    endfunction

    // One clock: check at negedge, update model, drive new inputs after posedge
    task automatic step();
        bit   acc;
        exp_t e;
        cmd_t c;
        @(negedge clk);
        check("cmd_err", cmd_err, err_exp);
        err_exp = 1'b0;
        check("cmd_ready", cmd_ready, exp_q.size() == 0);
        if (exp_q.size() == 0) begin
            check("out_valid_idle", out_valid, 0);
            check("data_ready_idle", data_ready, 0);
        end else begin
            check("data_ready", data_ready, !exp_q[0].hdr && out_ready);
        end
        if (held_hdr) begin
            check("hdr_hold_valid", out_valid, 1);
            check("hdr_hold_flit", out_flit, held_flit);
        end
        held_hdr = 0;
        if (out_valid && exp_q.size() > 0) begin
            if (out_ready) begin
                e = exp_q.pop_front();
                check(e.hdr ? "hdr_flit" : "body_flit", out_flit, e.flit);
                check(e.hdr ? "hdr_last" : "body_last", out_last, e.last);
                if (e.hdr) check("hdr_fwd_bit", out_flit[FW-1], 0);
            end else if (exp_q[0].hdr) begin
                held_hdr  = 1;
                held_flit = out_flit;
            end
        end
        if (data_valid && data_ready && dq.size() > 0) void'(dq.pop_front());
        acc = cmd_valid && cmd_ready;
        if (acc) begin
            if (model_legal(cur_cmd)) begin
                e.flit = model_header(cur_cmd);
                e.last = (cur_cmd.len == 0);
                e.hdr  = 1'b1;
                exp_q.push_back(e);
                for (int unsigned i = 0; i < cur_cmd.len; i++) begin
                    e.flit = $urandom;
                    e.last = (i == cur_cmd.len - 1);
                    e.hdr  = 1'b0;
                    exp_q.push_back(e);
                    dq.push_back(e.flit);
                end
            end else begin
                err_exp = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (acc) cmd_valid = 1'b0;
        if (!cmd_valid && cmd_list.size() > 0 && $urandom_range(0, 1) == 1) begin
            c          = cmd_list.pop_front();
            cur_cmd    = c;
            ready_mode = c.mode;
            cmd_valid  = 1'b1;
            cmd_mcast  = c.mcast;
            cmd_dest   = c.dest;
            cmd_bounds = c.bounds;
            cmd_tag    = c.tag;
            cmd_len    = LW'(c.len);
        end
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        data_valid = (dq.size() > 0) && (ready_mode == 0 || $urandom_range(0, 3) != 0);
        data_flit  = (dq.size() > 0) ? dq[0] : FW'($urandom);
    endtask

    task automatic run_until_drained(input int max_cycles);
        int c;
        c = 0;
        while ((cmd_list.size() > 0 || cmd_valid || exp_q.size() > 0) && c < max_cycles) begin
            step();
            c++;
        end
        check("drain_in_time", c < max_cycles, 1);
        step();
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_cmd_err"}, cmd_err, 0);
        check({tag, "_data_ready"}, data_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_out_flit"}, out_flit, 0);
    endtask

    initial begin
        int          guard;
        int unsigned cy, cx, n, e, s, w;
        logic [3:0]  d;
        logic [7:0]  b;

        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_mcast  = 1'b0;
        cmd_dest   = '0;
        cmd_bounds = '0;
        cmd_tag    = '0;
        cmd_len    = '0;
        data_flit  = '0;
        data_valid = 1'b0;
        out_ready  = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed cases
        cmd_list.push_back(mk_cmd(1'b0, 4'h9, 8'h00, 19'd5, 3, 0));
        cmd_list.push_back(mk_cmd(1'b0, 4'h3, 8'h00, 19'd0, 0, 0));
        cmd_list.push_back(mk_cmd(1'b1, 4'h5, {2'd0, 2'd0, 2'd3, 2'd2}, 19'h1234, 1, 0));
        cmd_list.push_back(mk_cmd(1'b1, 4'h5, {2'd0, 2'd0, 2'd3, 2'd0}, 19'h0007, 2, 0));
        cmd_list.push_back(mk_cmd(1'b0, 4'hA, 8'h00, 19'h00042, 2, 1));
        cmd_list.push_back(mk_cmd(1'b0, 4'h6, 8'h00, 19'h7FFFF, 255, 0));
        run_until_drained(2000);

        // Random traffic, mostly legal regions with some arbitrary bounds
        for (int k = 0; k < 60; k++) begin
            d  = 4'($urandom);
            cy = int'(d) / 4;
            cx = int'(d) % 4;
            if ($urandom_range(0, 3) == 0) begin
                b = 8'($urandom);
            end else begin
                n = $urandom_range(cy, 3);
                s = $urandom_range(0, cy);
                e = $urandom_range(cx, 3);
                w = $urandom_range(0, cx);
                b = 8'(w * 64 + s * 16 + e * 4 + n);
            end
            cmd_list.push_back(mk_cmd(1'($urandom), d, b, 19'($urandom),
                                      $urandom_range(0, 6), $urandom_range(0, 2)));
        end
        run_until_drained(5000);

        // Reset in BODY with two payload flits outstanding
        cmd_list.push_back(mk_cmd(1'b0, 4'hC, 8'h00, 19'h00011, 4, 0));
        guard = 0;
        while (!(exp_q.size() == 2 && !exp_q[0].hdr) && guard < 100) begin
            step();
            guard++;
        end
        check("reach_body_rem2", guard < 100, 1);
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        data_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        exp_q.delete();
        dq.delete();
        err_exp  = 1'b0;
        held_hdr = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cmd_list.push_back(mk_cmd(1'b1, 4'h5, {2'd1, 2'd0, 2'd2, 2'd3}, 19'h00023, 1, 0));
        run_until_drained(200);
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
